// File: rtl/truth_table_scanner.sv
// truth_table_scanner
//
// Walks every input combination 0 .. 2**N_IN-1 onto the function block under test in ascending
// order. Each vector is held for SETTLE cycles and then sampled for one capture cycle. The
// sampled bits build a truth-table word and a running ones count.
//
// Parameters:
//   N_IN        width of the function-block input vector
//   SETTLE      cycles each vector is held before func_out is sampled (1..15)
//
// Ports:
//   clk          single clock, rising edge
//   rst          asynchronous, active-high reset
//   start        begin a full scan; only looked at in idle
//   abort        cancel a running scan; only looked at while busy
//   func_out     output F of the function block under scan
//   func_in      vector driven into the function block
//   busy         high while waiting or capturing
//   done         one-cycle pulse when a scan completes
//   table_valid  truth_table and ones_count hold a complete scan
//   truth_table  bit v = func_out sampled while func_in == v ("table" is a reserved word)
//   ones_count   number of 1 bits in truth_table

module truth_table_scanner #(
   parameter int unsigned N_IN   = 5,
   parameter int unsigned SETTLE = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic                 func_out,
   output logic [N_IN-1:0]      func_in,
   output logic                 busy,
   output logic                 done,
   output logic                 table_valid,
   output logic [2**N_IN-1:0]   truth_table,
   output logic [N_IN:0]        ones_count
);

   // Settle counter reloads to SETTLE-1 so that WAIT lasts exactly SETTLE cycles.
   localparam logic [3:0] CntReload = 4'(SETTLE - 1);

   localparam logic [N_IN-1:0] InOne  = {{(N_IN-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StCapture,
      StFinish
   } state_e;

   state_e     state;
   logic [3:0] wait_cnt;

   // Status outputs are decoded straight from the state register.
   assign busy = (state == StWait) || (state == StCapture);
   assign done = (state == StFinish);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= StIdle;
         wait_cnt    <= 4'd0;
         func_in     <= '0;
         table_valid <= 1'b0;
         truth_table <= '0;
         ones_count  <= '0;
      end else begin
         unique case (state)
            StIdle: begin
               if (start) begin
                  state       <= StWait;
                  wait_cnt    <= CntReload;
                  func_in     <= '0;
                  table_valid <= 1'b0;
                  truth_table <= '0;
                  ones_count  <= '0;
               end
            end

            StWait: begin
               // Abort leaves partial results and func_in in place for inspection.
               if (abort) begin
                  state <= StIdle;
               end else if (wait_cnt == 4'd0) begin
                  state <= StCapture;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end

            StCapture: begin
               if (abort) begin
                  state <= StIdle;
               end else begin
                  truth_table[func_in] <= func_out;
                  ones_count           <= ones_count + {{N_IN{1'b0}}, func_out};
                  // The last vector exits to FINISH, so func_in never wraps.
                  if (&func_in) begin
                     state <= StFinish;
                  end else begin
                     func_in  <= func_in + InOne;
                     wait_cnt <= CntReload;
                     state    <= StWait;
                  end
               end
            end

            StFinish: begin
               table_valid <= 1'b1;
               state       <= StIdle;
            end

            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Testbench for truth_table_scanner: two instances (SETTLE=1 and SETTLE=3), each fed by a
// function model that is a plain lookup into a pattern word, so func_out = pattern[func_in].

module tb_truth_table_scanner;

   localparam int unsigned N_IN = 5;
   localparam int unsigned TW   = 32;
   localparam logic [31:0] Golden = 32'hB32D224C;

   logic clk = 1'b0;
   logic rst;

   logic start1, abort1, start3, abort3;
   logic [TW-1:0] model1, model3;
   logic func_out1, func_out3;

   logic [N_IN-1:0] func_in1, func_in3;
   logic            busy1, busy3, done1, done3, valid1, valid3;
   logic [TW-1:0]   table1, table3;
   logic [N_IN:0]   ones1, ones3;

   assign func_out1 = model1[func_in1];
   assign func_out3 = model3[func_in3];

   truth_table_scanner #(.N_IN(N_IN), .SETTLE(1)) dut1 (
      .clk         (clk),
      .rst         (rst),
      .start       (start1),
      .abort       (abort1),
      .func_out    (func_out1),
      .func_in     (func_in1),
      .busy        (busy1),
      .done        (done1),
      .table_valid (valid1),
      .truth_table (table1),
      .ones_count  (ones1)
   );

   truth_table_scanner #(.N_IN(N_IN), .SETTLE(3)) dut3 (
      .clk         (clk),
      .rst         (rst),
      .start       (start3),
      .abort       (abort3),
      .func_out    (func_out3),
      .func_in     (func_in3),
      .busy        (busy3),
      .done        (done3),
      .table_valid (valid3),
      .truth_table (table3),
      .ones_count  (ones3)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int          sel;
      logic [31:0] pat;
      logic        poke;
      int          exp_edge;
      int          exp_ones;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_start(input int sel, input logic v);
      if (sel == 1) start1 = v;
      else          start3 = v;
   endtask

   // One full scan on the selected instance; samples are taken 1 time unit after each edge,
   // sample k follows edge k where edge 0 is the edge that accepts start.
   task automatic run_scan(input int sel, input logic [31:0] pat, input logic poke,
                           input int exp_edge, input int exp_ones);
      int              hold[32];
      int              done_edge = -1;
      int              done_cnt  = 0;
      int              bad_hold  = 0;
      int              s         = (sel == 1) ? 1 : 3;
      logic            b, d;
      logic [N_IN-1:0] fi;
      foreach (hold[i]) hold[i] = 0;
      if (sel == 1) model1 = pat;
      else          model3 = pat;
      set_start(sel, 1'b1);
      tick();
      set_start(sel, 1'b0);
      for (int k = 0; k < 400; k++) begin
         b  = (sel == 1) ? busy1 : busy3;
         d  = (sel == 1) ? done1 : done3;
         fi = (sel == 1) ? func_in1 : func_in3;
         if (b) hold[fi]++;
         if (d) begin
            done_cnt++;
            if (done_edge < 0) done_edge = k;
         end
         // Stray start pulses while the scan runs must be ignored.
         if (poke) set_start(sel, b && (fi == 5'd3 || fi == 5'd20));
         if (done_edge >= 0 && k == done_edge + 1) break;
         tick();
      end
      set_start(sel, 1'b0);
      foreach (hold[i]) if (hold[i] != s + 1) bad_hold++;
      check($sformatf("scan%0d done_edge", sel), 64'(done_edge), 64'(exp_edge));
      check($sformatf("scan%0d done_count", sel), 64'(done_cnt), 64'd1);
      check($sformatf("scan%0d table", sel), 64'((sel == 1) ? table1 : table3), 64'(pat));
      check($sformatf("scan%0d ones", sel), 64'((sel == 1) ? ones1 : ones3), 64'(exp_ones));
      check($sformatf("scan%0d valid", sel), 64'((sel == 1) ? valid1 : valid3), 64'd1);
      check($sformatf("scan%0d func_in_end", sel), 64'((sel == 1) ? func_in1 : func_in3), 64'd31);
      check($sformatf("scan%0d bad_hold_vectors", sel), 64'(bad_hold), 64'd0);
   endtask

   initial begin
      int d0, d1, guard, dcnt;

      vecs[0] = '{1, 32'hB32D224C, 1'b0, 64,  14};
      vecs[1] = '{3, 32'hFFFFFFFF, 1'b0, 128, 32};
      vecs[2] = '{1, 32'hAAAAAAAA, 1'b0, 64,  16};
      vecs[3] = '{3, 32'h00000000, 1'b0, 128, 0};
      vecs[4] = '{1, 32'h80000001, 1'b0, 64,  2};
      vecs[5] = '{1, 32'hB32D224C, 1'b1, 64,  14};
      vecs[6] = '{3, 32'h0F0F0F0F, 1'b1, 128, 16};

      rst = 1'b1;
      start1 = 1'b0; abort1 = 1'b0; start3 = 1'b0; abort3 = 1'b0;
      model1 = Golden; model3 = '0;
      tick();
      tick();
      check("reset busy", 64'(busy1), 64'd0);
      check("reset done", 64'(done1), 64'd0);
      check("reset valid", 64'(valid1), 64'd0);
      check("reset table", 64'(table1), 64'd0);
      check("reset ones", 64'(ones1), 64'd0);
      check("reset func_in", 64'(func_in1), 64'd0);
      rst = 1'b0;
      tick();

      // Idle with no start: nothing moves.
      tick();
      check("idle busy", 64'(busy1), 64'd0);

      for (int i = 0; i < 7; i++) begin
         run_scan(vecs[i].sel, vecs[i].pat, vecs[i].poke, vecs[i].exp_edge, vecs[i].exp_ones);
         tick();
      end

      // Abort while func_in == 7: vectors 0..6 captured, nothing else.
      model1 = Golden;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      guard = 0;
      while (func_in1 != 5'd7 && guard < 40) begin
         tick();
         guard++;
      end
      check("abort reach_7", 64'(func_in1), 64'd7);
      abort1 = 1'b1;
      tick();
      abort1 = 1'b0;
      check("abort busy", 64'(busy1), 64'd0);
      check("abort func_in", 64'(func_in1), 64'd7);
      check("abort valid", 64'(valid1), 64'd0);
      check("abort table", 64'(table1), 64'h4C);
      check("abort ones", 64'(ones1), 64'd3);
      dcnt = 0;
      for (int k = 0; k < 80; k++) begin
         if (done1 || busy1) dcnt++;
         tick();
      end
      check("abort no_done_or_busy", 64'(dcnt), 64'd0);
      run_scan(1, Golden, 1'b0, 64, 14);
      tick();

      // Back-to-back scans with start held high; func_out = func_in[0].
      model1 = 32'hAAAAAAAA;
      d0 = -1;
      d1 = -1;
      start1 = 1'b1;
      tick();
      check("b2b valid_cleared", 64'(valid1), 64'd0);
      for (int k = 0; k < 300; k++) begin
         if (done1) begin
            if (d0 < 0) d0 = k;
            else if (d1 < 0) begin
               d1 = k;
               start1 = 1'b0;
            end
         end
         if (k == 65) check("b2b valid_between", 64'(valid1), 64'd1);
         if (k == 66) begin
            check("b2b valid_second_start", 64'(valid1), 64'd0);
            check("b2b busy_second_start", 64'(busy1), 64'd1);
         end
         if (d1 >= 0 && k == d1 + 1) break;
         tick();
      end
      start1 = 1'b0;
      check("b2b first_done", 64'(d0), 64'd64);
      check("b2b done_spacing", 64'(d1 - d0), 64'd66);
      check("b2b table", 64'(table1), 64'hAAAAAAAA);
      check("b2b ones", 64'(ones1), 64'd16);
      check("b2b valid_final", 64'(valid1), 64'd1);
      tick();

      // Asynchronous reset at vector 10, asserted away from the clock edge.
      model1 = Golden;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      guard = 0;
      while (func_in1 != 5'd10 && guard < 40) begin
         tick();
         guard++;
      end
      check("rst_mid reach_10", 64'(func_in1), 64'd10);
      #2;
      rst = 1'b1;
      #1;
      check("rst_mid busy", 64'(busy1), 64'd0);
      check("rst_mid table", 64'(table1), 64'd0);
      check("rst_mid ones", 64'(ones1), 64'd0);
      check("rst_mid func_in", 64'(func_in1), 64'd0);
      check("rst_mid valid", 64'(valid1), 64'd0);
      tick();
      rst = 1'b0;
      tick();
      check("rst_mid stays_idle", 64'(busy1), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
